// File: rtl/ring_pkg.sv
// Shared encodings for the ring position decoder: direction codes and lock FSM states.
package ring_pkg;

  localparam logic [1:0] DIR_HOLD  = 2'b00;
  localparam logic [1:0] DIR_LEFT  = 2'b01;
  localparam logic [1:0] DIR_RIGHT = 2'b10;
  localparam logic [1:0] DIR_JUMP  = 2'b11;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } state_t;

endpackage

// File: rtl/onehot_encoder.sv
// Combinational one-hot check and binary encode of a WIDTH-bit vector.
module onehot_encoder #(
  parameter int WIDTH = 280,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             is_onehot
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0][IDX_W-1:0] masked;
  logic [CNT_W-1:0]            cnt;

  for (genvar g = 0; g < WIDTH; g++) begin : g_mask
    assign masked[g] = vec[g] ? IDX_W'(g) : '0;
  end

  // idx is only meaningful when exactly one bit is set
  always_comb begin
    cnt = '0;
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt = cnt + CNT_W'(vec[i]);
      idx = idx | masked[i];
    end
  end

  assign is_onehot = (cnt == CNT_W'(1));

endmodule

// File: rtl/ring_position_decoder.sv
// Two-stage ring counter receiver: sample, encode, infer step direction, count revolutions.
module ring_position_decoder
  import ring_pkg::*;
#(
  parameter int WIDTH = 280,
  parameter int IDX_W = $clog2(WIDTH),
  parameter int REV_W = 16
) (
  input  logic             clock0,
  input  logic             reset,
  input  logic [WIDTH-1:0] ring_in,
  input  logic             in_valid,
  input  logic             clear_err,
  output logic [IDX_W-1:0] pos_idx,
  output logic             pos_valid,
  output logic             onehot_ok,
  output logic [1:0]       dir,
  output logic [REV_W-1:0] rev_count,
  output logic             err_sticky
);

  localparam int               STAGES = 2;
  localparam logic [IDX_W-1:0] LAST   = IDX_W'(WIDTH - 1);

  logic [STAGES:1]  vld_pipe;
  logic [WIDTH-1:0] ring_q;
  logic [IDX_W-1:0] enc_idx;
  logic             enc_ok;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ref_q, ref_d;
  logic [IDX_W-1:0] idx_d;
  logic             ok_d, err_d, err_hit;
  logic [1:0]       dir_d;
  logic [REV_W-1:0] rev_d;
  logic [IDX_W-1:0] left_n, right_n;

  always_ff @(posedge clock0) begin
    if (reset) begin
      vld_pipe <= '0;
      ring_q   <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
      ring_q   <= ring_in;
    end
  end

  onehot_encoder #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_enc (
    .vec       (ring_q),
    .idx       (enc_idx),
    .is_onehot (enc_ok)
  );

  assign left_n  = (ref_q == LAST) ? '0 : ref_q + IDX_W'(1);
  assign right_n = (ref_q == '0) ? LAST : ref_q - IDX_W'(1);

  // Left is tested before right so WIDTH==2 resolves to a left step
  always_comb begin
    state_d = state_q;
    ref_d   = ref_q;
    idx_d   = pos_idx;
    ok_d    = onehot_ok;
    dir_d   = dir;
    rev_d   = rev_count;
    err_hit = 1'b0;
    if (vld_pipe[1]) begin
      if (!enc_ok) begin
        ok_d    = 1'b0;
        dir_d   = DIR_JUMP;
        err_hit = 1'b1;
        state_d = UNLOCKED;
      end else begin
        ok_d    = 1'b1;
        idx_d   = enc_idx;
        ref_d   = enc_idx;
        state_d = LOCKED;
        if (state_q == UNLOCKED) begin
          dir_d = DIR_JUMP;
        end else if (enc_idx == ref_q) begin
          dir_d = DIR_HOLD;
        end else if (enc_idx == left_n) begin
          dir_d = DIR_LEFT;
          if (ref_q == LAST) rev_d = rev_count + REV_W'(1);
        end else if (enc_idx == right_n) begin
          dir_d = DIR_RIGHT;
          if (ref_q == '0) rev_d = rev_count - REV_W'(1);
        end else begin
          dir_d   = DIR_JUMP;
          err_hit = 1'b1;
        end
      end
    end
    err_d = err_hit ? 1'b1 : (clear_err ? 1'b0 : err_sticky);
  end

  always_ff @(posedge clock0) begin
    if (reset) begin
      state_q    <= UNLOCKED;
      ref_q      <= '0;
      pos_idx    <= '0;
      onehot_ok  <= 1'b0;
      dir        <= DIR_HOLD;
      rev_count  <= '0;
      err_sticky <= 1'b0;
    end else begin
      state_q    <= state_d;
      ref_q      <= ref_d;
      pos_idx    <= idx_d;
      onehot_ok  <= ok_d;
      dir        <= dir_d;
      rev_count  <= rev_d;
      err_sticky <= err_d;
    end
  end

  assign pos_valid = vld_pipe[STAGES];

endmodule

// File: tb/tb_ring_position_decoder.sv
// Randomized scoreboard bench for ring_position_decoder against a modular-arithmetic reference model.
module tb_ring_position_decoder;

  localparam int W     = 280;
  localparam int IDX_W = $clog2(W);
  localparam int REV_W = 16;

  logic             clock0 = 1'b0;
  logic             reset = 1'b1;
  logic [W-1:0]     ring_in = '0;
  logic             in_valid = 1'b0;
  logic             clear_err = 1'b0;
  logic [IDX_W-1:0] pos_idx;
  logic             pos_valid;
  logic             onehot_ok;
  logic [1:0]       dir;
  logic [REV_W-1:0] rev_count;
  logic             err_sticky;

  ring_position_decoder #(.WIDTH(W), .IDX_W(IDX_W), .REV_W(REV_W)) dut (
    .clock0     (clock0),
    .reset      (reset),
    .ring_in    (ring_in),
    .in_valid   (in_valid),
    .clear_err  (clear_err),
    .pos_idx    (pos_idx),
    .pos_valid  (pos_valid),
    .onehot_ok  (onehot_ok),
    .dir        (dir),
    .rev_count  (rev_count),
    .err_sticky (err_sticky)
  );

  always #5 clock0 = ~clock0;

  int cyc = 0;
  always @(posedge clock0) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [IDX_W-1:0] idx;
    logic             ok;
    logic [1:0]       dir;
    logic [REV_W-1:0] rev;
    logic             err;
    int               due;
  } exp_t;

  exp_t q[$];

  // reference model state
  bit               m_locked;
  int               m_ref;
  logic [REV_W-1:0] m_rev;
  bit               m_err;
  logic [IDX_W-1:0] m_idx;
  bit               m_ok;
  logic [1:0]       m_dir;
  bit               p_v;
  logic [W-1:0]     p_r;

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] oh(int i);
    logic [W-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    m_locked = 0; m_ref = 0; m_rev = '0; m_err = 0;
    m_idx = '0; m_ok = 0; m_dir = 2'b00; p_v = 0;
  endtask

  // One clock edge of the decoder: sample v/r (issued last cycle) with this cycle's clear
  task automatic model_edge(bit v, logic [W-1:0] r, bit clr);
    bit hit;
    int n, d;
    exp_t e;
    hit = 0;
    if (v) begin
      if ($countones(r) != 1) begin
        m_ok = 0; m_dir = 2'b11; hit = 1; m_locked = 0;
      end else begin
        n = 0;
        for (int i = 0; i < W; i++) if (r[i]) n = i;
        m_ok  = 1;
        m_idx = IDX_W'(n);
        if (!m_locked) m_dir = 2'b11;
        else begin
          d = (n - m_ref + W) % W;
          if (d == 0) m_dir = 2'b00;
          else if (d == 1) begin
            m_dir = 2'b01;
            if (n == 0) m_rev = m_rev + 1'b1;
          end else if (d == W - 1) begin
            m_dir = 2'b10;
            if (n == W - 1) m_rev = m_rev - 1'b1;
          end else begin
            m_dir = 2'b11; hit = 1;
          end
        end
        m_ref = n;
        m_locked = 1;
      end
    end
    m_err = hit ? 1'b1 : (clr ? 1'b0 : m_err);
    if (v) begin
      e.idx = m_idx; e.ok = m_ok; e.dir = m_dir; e.rev = m_rev; e.err = m_err;
      e.due = cyc + 1;
      q.push_back(e);
    end
  endtask

  task automatic drive(bit rst, bit v, logic [W-1:0] r, bit clr);
    @(negedge clock0);
    reset = rst; in_valid = v; ring_in = r; clear_err = clr;
    if (rst) model_reset();
    else model_edge(p_v, p_r, clr);
    p_v = rst ? 1'b0 : v;
    p_r = r;
  endtask

  task automatic check_all_zero(string tag);
    chk({tag, "_pos_valid"}, pos_valid, 0);
    chk({tag, "_pos_idx"}, pos_idx, 0);
    chk({tag, "_onehot_ok"}, onehot_ok, 0);
    chk({tag, "_dir"}, dir, 0);
    chk({tag, "_rev_count"}, rev_count, 0);
    chk({tag, "_err_sticky"}, err_sticky, 0);
  endtask

  exp_t me;
  always @(negedge clock0) begin
    if (pos_valid) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_pos_valid: got strobe expected none (cycle %0d)", cyc);
      end else begin
        me = q.pop_front();
        chk("latency_cycle", cyc, me.due);
        chk("pos_idx", pos_idx, me.idx);
        chk("onehot_ok", onehot_ok, me.ok);
        chk("dir", dir, me.dir);
        chk("rev_count", rev_count, me.rev);
        chk("err_sticky", err_sticky, me.err);
      end
    end
  end

  initial begin
    int gpos, kind, a, b;
    bit v, clr;
    logic [W-1:0] r;
    model_reset();
    drive(1, 0, '0, 0);
    drive(1, 0, '0, 0);
    drive(0, 0, '0, 0);
    check_all_zero("reset");

    // wrap left 279 -> 0 -> 1, then right wrap 0 -> 279
    drive(0, 1, oh(279), 0);
    drive(0, 1, oh(0), 0);
    drive(0, 1, oh(1), 0);
    drive(0, 1, oh(0), 0);
    drive(0, 1, oh(279), 0);
    // zero and two-hot samples, then relock
    drive(0, 1, '0, 0);
    drive(0, 1, oh(3) | oh(200), 0);
    drive(0, 1, oh(7), 0);
    // jump while locked, then continue left
    drive(0, 1, oh(5), 0);
    drive(0, 1, oh(9), 0);
    drive(0, 1, oh(10), 0);
    // clear, then clear colliding with a jump error, then clear alone
    drive(0, 0, '0, 1);
    drive(0, 1, oh(11), 0);
    drive(0, 1, oh(50), 0);
    drive(0, 0, '0, 1);
    drive(0, 0, '0, 0);
    chk("err_after_collide", err_sticky, 1);
    drive(0, 0, '0, 1);
    drive(0, 0, '0, 0);
    chk("err_after_clear", err_sticky, 0);
    chk("err_after_clear_model", err_sticky, m_err);

    // randomized walk
    gpos = 270;
    for (int i = 0; i < 600; i++) begin
      v    = ($urandom_range(3, 0) != 0);
      clr  = ($urandom_range(9, 0) == 0);
      kind = $urandom_range(19, 0);
      if (kind <= 5 || kind >= 18) gpos = (gpos + 1) % W;
      else if (kind <= 10) gpos = (gpos + W - 1) % W;
      else if (kind >= 14 && kind <= 15) gpos = $urandom_range(W - 1, 0);
      r = oh(gpos);
      if (kind == 16) r = '0;
      if (kind == 17) begin
        a = $urandom_range(W - 1, 0);
        b = (a + $urandom_range(W - 1, 1)) % W;
        r = oh(a) | oh(b);
      end
      drive(0, v, r, clr);
    end

    // back-to-back full revolution, then reset with samples in flight
    drive(1, 0, '0, 0);
    for (int i = 0; i < W + 2; i++) drive(0, 1, oh(i % W), 0);
    drive(1, 0, '0, 0);
    for (int i = 0; i < 5; i++) drive(0, 0, '0, 0);
    check_all_zero("midreset");

    for (int i = 0; i < 4; i++) drive(0, 0, '0, 0);
    chk("scoreboard_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
